// File: rtl/arith_pkg.sv
// arith_pkg: shared constants, mode encoding and stage record for the arithmetic datapath
package arith_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int num_stages(input int width, input int seg);
        return width / seg;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [DEF_WIDTH-1:0] s;
        logic                 c;
    } stage_rec_t;

endpackage

// File: rtl/seg_adder.sv
// seg_adder: combinational SEG-bit adder slice
//   a, b : SEG-bit addends
//   cin  : carry in
//   s    : SEG-bit sum
//   cout : carry out of the slice MSB
module seg_adder #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segment-pipelined add/sub, one SEG-bit slice per stage, valid/ready on both sides
//   clk, rst            : clock, async active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
module pipelined_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = num_stages(WIDTH, SEG);

    if (WIDTH % SEG != 0 || STAGES < 1) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG");
    end

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
    } beat_t;

    beat_t          st  [STAGES];
    beat_t          src [STAGES];
    logic [SEG-1:0] ss  [STAGES];
    logic           cc  [STAGES];
    logic           adv;

    // whole pipe moves as one; a full output slot that is not taken freezes everything
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // subtract is a + ~b + 1, so cin is ignored in that mode
    assign src[0] = {in_valid, a, (sub == MODE_SUB) ? ~b : b, {WIDTH{1'b0}},
                     (sub == MODE_SUB) ? 1'b1 : cin};

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign src[k] = st[k-1];
        end
        seg_adder #(.SEG(SEG)) u_add (
            .a   (src[k].a[k*SEG +: SEG]),
            .b   (src[k].b[k*SEG +: SEG]),
            .cin (src[k].c),
            .s   (ss[k]),
            .cout(cc[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) st[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                st[i]                <= src[i];
                st[i].s[i*SEG +: SEG] <= ss[i];
                st[i].c              <= cc[i];
            end
        end
    end

    assign out_valid = st[STAGES-1].v;
    assign sum       = st[STAGES-1].s;
    assign cout      = st[STAGES-1].c;
    assign ovf       = (st[STAGES-1].a[WIDTH-1] == st[STAGES-1].b[WIDTH-1]) &
                       (st[STAGES-1].s[WIDTH-1] != st[STAGES-1].a[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed self-checking bench for pipelined_addsub (16/4 and 8/8 configs)
module tb_pipelined_addsub;

    logic        clk, rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid_8, in_ready_8, cin_8, sub_8, out_valid_8, out_ready_8, cout_8, ovf_8;
    logic [7:0]  a_8, b_8, sum_8;

    int n_chk  = 0;
    int n_fail = 0;

    pipelined_addsub #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_addsub #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .cin(cin_8), .sub(sub_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8),
        .sum(sum_8), .cout(cout_8), .ovf(ovf_8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, input logic ts,
                       input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1;
        lat = 0;
        do begin
            tick();
            in_valid = 0;
            lat++;
        end while (!out_valid && lat < 10);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        int acc, nv;
        rst = 1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
        in_valid_8 = 0; a_8 = 0; b_8 = 0; cin_8 = 0; sub_8 = 0; out_ready_8 = 1;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ready", in_ready, 1);
        #10 rst = 0;
        tick();

        run("add_ovf", 16'h8000, 16'hC000, 0, 0, 16'h4000, 1, 1);
        run("sub_borrow", 16'h0007, 16'h000B, 0, 1, 16'hFFFC, 0, 0);
        run("sub_ovf", 16'h7FFF, 16'hFFFF, 0, 1, 16'h8000, 0, 1);
        run("sub_pos", 16'h0005, 16'h0003, 0, 1, 16'h0002, 1, 0);
        run("add_cin", 16'h1234, 16'h0FFF, 1, 0, 16'h2234, 0, 0);
        run("sub_nocin", 16'h0010, 16'h0001, 1, 1, 16'h000F, 1, 0);

        for (int c = 0; c < 19; c++) begin
            if (c < 16) begin
                a = 16'(c); b = 16'h00FF; cin = 1; sub = 0; in_valid = 1;
                check("b2b_ready", in_ready, 1);
            end else in_valid = 0;
            tick();
            if (c >= 3) begin
                check("b2b_valid", out_valid, 1);
                check("b2b_sum", sum, 32'(c - 3 + 16'h100));
            end
        end
        tick();
        check("b2b_end", out_valid, 0);

        out_ready = 0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            a = 16'(16'h1111 * (acc + 1)); b = 16'h0101; cin = 0; sub = 0; in_valid = 1;
            if (in_ready) begin
                exp_q.push_back(a + b);
                acc++;
            end
            tick();
        end
        check("bp_accepted", acc, 4);
        check("bp_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_sum", sum, 16'h1212);
        tick();
        check("bp_hold", sum, 16'h1212);
        check("bp_hold_valid", out_valid, 1);
        in_valid = 0; out_ready = 1;
        for (int t = 0; t < 12 && exp_q.size() > 0; t++) begin
            if (out_valid) check("bp_out", sum, exp_q.pop_front());
            tick();
        end
        check("bp_left", exp_q.size(), 0);

        for (int c = 0; c < 4; c++) begin
            a = 16'hFFFF; b = 16'h0002; cin = 0; sub = 0; in_valid = 1;
            tick();
        end
        in_valid = 0;
        check("rst_pre_valid", out_valid, 1);
        check("rst_pre_sum", sum, 16'h0001);
        #2 rst = 1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        check("arst_ovf", ovf, 0);
        #1 rst = 0;
        nv = 0;
        repeat (8) begin
            tick();
            if (out_valid) nv++;
        end
        check("rst_stale", nv, 0);
        check("rst_ready_after", in_ready, 1);

        a_8 = 8'hFF; b_8 = 8'h01; cin_8 = 0; sub_8 = 0; in_valid_8 = 1;
        check("w8_pre_valid", out_valid_8, 0);
        tick();
        in_valid_8 = 0;
        check("w8_valid", out_valid_8, 1);
        check("w8_sum", sum_8, 8'h00);
        check("w8_cout", cout_8, 1);
        check("w8_ovf", ovf_8, 0);
        tick();
        check("w8_drain", out_valid_8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, segment-pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output. The WIDTH-bit operation is split into SEG-bit slices, one slice per pipeline stage, with carry registered between stages. This keeps the per-stage carry chain short and sustains one operation per clock. The block sits between operand producers and result consumers in the arithmetic datapath and is the generalised, sequential successor to the fixed 4-bit ripple adder.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of SEG.
- SEG, 4: bits added per pipeline stage; STAGES = WIDTH/SEG, must be ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only in add mode.
- sub  input  1  0 = A+B+cin; 1 = A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow.

## Operation
- On accept (in_valid & in_ready), the block captures a, b' and c0 into stage 0.
  - Add: b' = b, c0 = cin.
  - Sub: b' = ~b, c0 = 1.
- Stage k (0..STAGES−1) adds slice k of a and b' plus the registered carry from stage k−1 (stage 0 uses c0).
  - It writes result slice k and carry out to the stage k register.
  - Unprocessed upper slices of a and b' travel with the beat.
  - Completed lower result slices travel with the beat.
- Each stage holds a valid bit. Every stage carries full-width a, b' and partial sum; synthesis trims unused bits.
- Output stage:
  - sum: assembled result slices.
  - cout: carry from the final slice.
  - ovf = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]).
- Wrap-around: the result is modulo 2^WIDTH; no saturation.
- The block has no FSM. The pipeline is a chain of valid-tagged registers under one global advance enable:
  - adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv = 0, every stage register holds.
  - When adv = 1, every stage shifts one place; a bubble shifts in if in_valid = 0.
- The output registers are the last stage. out_valid is the last stage's valid bit. sum, cout and ovf hold stable while out_valid & ~out_ready.
- Simultaneous accept and output consume in the same cycle are legal, giving full throughput.
- Reset values: all valid bits 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. in_ready = 1 combinationally after reset.
- Reset mid-operation discards all in-flight beats. No partial result is ever presented.
- Elaboration fails if WIDTH % SEG ≠ 0.

## Timing
- Latency: a beat accepted at edge n is presented with out_valid = 1 after edge n+STAGES (4 for defaults) when there is no backpressure.
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure stalls the whole pipe; no beat is lost or duplicated.
- in_ready depends combinationally on out_ready; there is no other combinational input-to-output path.
- Critical path: one SEG-bit carry chain plus the advance mux.

## Structure
- Shared package arith_pkg:
  - localparam function for STAGES.
  - Mode encoding: MODE_ADD = 0, MODE_SUB = 1.
  - Stage record typedef (valid, a, b', partial sum, carry), parametrised via the package's WIDTH default.
- Sub-module seg_adder: combinational SEG-bit adder (a, b, cin → s, cout), instantiated once per stage inside a generate loop.
- All registers live in pipelined_addsub.

## Test plan
- Defaults, out_ready = 1: sub = 0, a = 0x8000, b = 0xC000, cin = 0 → after 4 cycles sum = 0x4000, cout = 1, ovf = 1.
- sub = 1, a = 0x0007, b = 0x000B → sum = 0xFFFC, cout = 0 (borrow), ovf = 0. Then a = 0x7FFF, b = 0xFFFF (i.e. 0x7FFF − (−1)) → sum = 0x8000, cout = 0, ovf = 1.
- 16 back-to-back beats, a = i, b = 0x00FF, cin = 1 → 16 consecutive results i + 0x100 in order, no gaps, in_ready constantly 1.
- Hold out_ready = 0 for 5 cycles while feeding beats → in_ready drops once out_valid = 1; outputs stay stable; all beats emerge in order once out_ready = 1.
- Assert rst with 3 beats in flight → out_valid = 0 and sum/cout/ovf = 0 immediately (asynchronously); no stale result appears after release.
- WIDTH = 8, SEG = 8 (single stage): a = 0xFF, b = 0x01, cin = 0 → latency 1, sum = 0x00, cout = 1, ovf = 0.
